// File: rtl/div_arbiter.sv
// Round-robin front end that shares one sequential signed divider among NREQ clients.
// Drives the divider's level en/done handshake and returns a tagged one-cycle result.
module div_arbiter #(
  parameter int NREQ      = 4,
  parameter int IDW       = 2,
  parameter int TO_CYCLES = 200
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [32*NREQ-1:0]   req_opA,
  input  logic [32*NREQ-1:0]   req_opB,
  output logic [NREQ-1:0]      resp_valid,
  output logic [31:0]          resp_res,
  output logic [IDW-1:0]       resp_id,
  output logic                 div_en,
  output logic [31:0]          div_opA,
  output logic [31:0]          div_opB,
  input  logic                 div_done,
  input  logic [31:0]          div_res,
  output logic                 busy,
  output logic                 timeout_err
);

  // state | meaning
  // IDLE  | no operation; grant the round-robin winner
  // ARM   | en high, waiting for the divider to drop done
  // RUN   | en high, waiting for done to rise with the quotient
  // RESP  | en low, one-cycle response pulse to the owner
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam int TW = $clog2(TO_CYCLES + 1);

  logic [1:0]     state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] id;
  logic [IDW-1:0] win;
  logic [IDW-1:0] cand;
  logic [TW-1:0]  tmr;
  logic [31:0]    win_opA;
  logic [31:0]    win_opB;
  logic           any_req;
  logic           tmr_tc;

  assign any_req = |req_valid;
  assign tmr_tc  = (tmr == '0);
  assign div_en  = (state == S_ARM) || (state == S_RUN);
  assign busy    = (state != S_IDLE);

  // Walk downward so the lowest offset from ptr+1 is the last, winning, assignment.
  always_comb begin
    win  = ptr;
    cand = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = IDW'((int'(ptr) + k) % NREQ);
      if (req_valid[cand]) win = cand;
    end
  end

  always_comb begin
    win_opA = '0;
    win_opB = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == IDW'(i)) begin
        win_opA = req_opA[32*i +: 32];
        win_opB = req_opB[32*i +: 32];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == S_IDLE && any_req) req_ready[win] = 1'b1;
  end

  always_comb begin
    resp_valid = '0;
    if (state == S_RESP) resp_valid[id] = 1'b1;
  end

  // The timeout timer is loaded on accept and counts down through ARM and RUN.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state       <= S_IDLE;
      ptr         <= IDW'(NREQ - 1);
      id          <= '0;
      tmr         <= '0;
      div_opA     <= '0;
      div_opB     <= '0;
      resp_res    <= '0;
      resp_id     <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            div_opA <= win_opA;
            div_opB <= win_opB;
            id      <= win;
            ptr     <= win;
            tmr     <= TW'(TO_CYCLES - 1);
            state   <= S_ARM;
          end
        end
        S_ARM: begin
          if (tmr_tc) begin
            timeout_err <= 1'b1;
            resp_res    <= '0;
            resp_id     <= id;
            state       <= S_RESP;
          end else begin
            tmr <= tmr - 1'b1;
            if (!div_done) state <= S_RUN;
          end
        end
        S_RUN: begin
          if (div_done) begin
            resp_res <= div_res;
            resp_id  <= id;
            state    <= S_RESP;
          end else if (tmr_tc) begin
            timeout_err <= 1'b1;
            resp_res    <= '0;
            resp_id     <= id;
            state       <= S_RESP;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter with a behavioural sequential divider on the en/done side.
// Each scenario task drives stimulus and checks hand-computed results inline.
module tb_div_arbiter;

  localparam int NREQ      = 4;
  localparam int IDW       = 2;
  localparam int TO_CYCLES = 200;
  localparam int LAT       = 5;

  logic                 clk;
  logic                 nrst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [32*NREQ-1:0]   req_opA;
  logic [32*NREQ-1:0]   req_opB;
  logic [NREQ-1:0]      resp_valid;
  logic [31:0]          resp_res;
  logic [IDW-1:0]       resp_id;
  logic                 div_en;
  logic [31:0]          div_opA;
  logic [31:0]          div_opB;
  logic                 div_done;
  logic [31:0]          div_res;
  logic                 busy;
  logic                 timeout_err;

  logic                 div_stuck;
  logic                 dv_busy;
  logic                 dv_fin;
  int                   dv_cnt;

  int checks = 0;
  int errors = 0;

  div_arbiter #(.NREQ(NREQ), .IDW(IDW), .TO_CYCLES(TO_CYCLES)) dut (
    .clk(clk), .nrst(nrst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opA(req_opA), .req_opB(req_opB),
    .resp_valid(resp_valid), .resp_res(resp_res), .resp_id(resp_id),
    .div_en(div_en), .div_opA(div_opA), .div_opB(div_opB),
    .div_done(div_done), .div_res(div_res),
    .busy(busy), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return (a == 32'd0) ? 32'd1 : 32'hFFFF_FFFF;
    return $signed(a) / $signed(b);
  endfunction

  // Divider model: done high when idle, drops one cycle after sampling en, reads operands at the end.
  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      div_done <= 1'b1; dv_busy <= 1'b0; dv_fin <= 1'b0; dv_cnt <= 0; div_res <= '0;
    end else if (div_stuck) begin
      div_done <= 1'b1; dv_busy <= 1'b0; dv_fin <= 1'b0;
    end else if (dv_busy) begin
      if (dv_cnt == 0) begin
        div_done <= 1'b1; div_res <= ref_div(div_opA, div_opB); dv_busy <= 1'b0; dv_fin <= 1'b1;
      end else begin
        dv_cnt <= dv_cnt - 1;
      end
    end else if (!div_en) begin
      dv_fin <= 1'b0;
    end else if (!dv_fin && div_done) begin
      div_done <= 1'b0; dv_busy <= 1'b1; dv_cnt <= LAT - 1;
    end
  end

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
    req_opA[32*i +: 32] = a;
    req_opB[32*i +: 32] = b;
    req_valid[i] = 1'b1;
  endtask

  task automatic test_reset();
    nrst = 1'b0; req_valid = '0; req_opA = '0; req_opB = '0; div_stuck = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (req_ready !== 4'b0000 || resp_valid !== 4'b0000) begin
      errors++; $display("FAIL reset_handshake: ready=%b resp_valid=%b want 0000/0000", req_ready, resp_valid); end
    checks++; if (resp_res !== 32'd0 || resp_id !== 2'd0) begin
      errors++; $display("FAIL reset_resp: res=%h id=%0d want 0/0", resp_res, resp_id); end
    checks++; if (div_en !== 1'b0 || div_opA !== 32'd0 || div_opB !== 32'd0) begin
      errors++; $display("FAIL reset_div: en=%b opA=%h opB=%h want 0", div_en, div_opA, div_opB); end
    checks++; if (busy !== 1'b0 || timeout_err !== 1'b0) begin
      errors++; $display("FAIL reset_status: busy=%b terr=%b want 0/0", busy, timeout_err); end
    nrst = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_idle: busy=%b want 0", busy); end
  endtask

  task automatic test_round_robin();
    logic [31:0] exp_res [4];
    logic [3:0]  gnt;
    int n, lowcnt, e;
    exp_res[0] = 32'd20; exp_res[1] = 32'd15; exp_res[2] = 32'd12; exp_res[3] = 32'd10;
    @(posedge clk); #1;
    set_req(0, 32'd40, 32'd2); set_req(1, 32'd45, 32'd3);
    set_req(2, 32'd48, 32'd4); set_req(3, 32'd50, 32'd5);
    @(negedge clk);
    for (int g = 0; g < 5; g++) begin
      e = g % 4; gnt = '0; lowcnt = 0; n = 0;
      while (!div_en && n < 20) begin
        lowcnt++;
        if ((req_ready & req_valid) != '0) gnt = req_ready;
        @(negedge clk); n++;
      end
      checks++; if (gnt !== 4'(1 << e)) begin
        errors++; $display("FAIL rr_grant%0d: ready=%b want %b", g, gnt, 4'(1 << e)); end
      if (g > 0) begin
        checks++; if (lowcnt != 2) begin
          errors++; $display("FAIL rr_en_gap%0d: en low %0d cycles want 2", g, lowcnt); end
      end
      if (g == 4) req_valid = '0;
      n = 0;
      while (resp_valid == '0 && n < 100) begin @(negedge clk); n++; end
      checks++; if (resp_valid !== 4'(1 << e) || resp_id !== 2'(e) || resp_res !== exp_res[e]) begin
        errors++; $display("FAIL rr_resp%0d: valid=%b id=%0d res=%0d want %b/%0d/%0d",
                           g, resp_valid, resp_id, resp_res, 4'(1 << e), e, exp_res[e]); end
    end
  endtask

  task automatic test_single();
    int n;
    @(posedge clk); #1;
    set_req(0, 32'd100, 32'd7);
    @(negedge clk);
    checks++; if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL single_ready: ready=%b want 0001", req_ready); end
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0000 || busy !== 1'b1 || div_en !== 1'b1) begin
      errors++; $display("FAIL single_arm: ready=%b busy=%b en=%b want 0000/1/1", req_ready, busy, div_en); end
    n = 0;
    while (resp_valid == '0 && n < 100) begin @(negedge clk); n++; end
    checks++; if (resp_valid !== 4'b0001 || resp_id !== 2'd0 || resp_res !== 32'd14) begin
      errors++; $display("FAIL single_resp: valid=%b id=%0d res=%0d want 0001/0/14", resp_valid, resp_id, resp_res); end
    @(negedge clk);
    checks++; if (resp_valid !== 4'b0000 || busy !== 1'b0 || resp_res !== 32'd14) begin
      errors++; $display("FAIL single_after: valid=%b busy=%b res=%0d want 0000/0/14", resp_valid, busy, resp_res); end
  endtask

  task automatic test_signed();
    int n;
    logic stable;
    @(posedge clk); #1;
    set_req(2, 32'hFFFF_FF9C, 32'd7);
    @(negedge clk);
    checks++; if (req_ready !== 4'b0100) begin
      errors++; $display("FAIL signed_ready: ready=%b want 0100", req_ready); end
    @(posedge clk); #1;
    req_valid = '0;
    stable = 1'b1; n = 0;
    @(negedge clk);
    while (n < 100) begin
      if (div_opA !== 32'hFFFF_FF9C || div_opB !== 32'd7) stable = 1'b0;
      if (resp_valid != '0) break;
      @(negedge clk); n++;
    end
    checks++; if (stable !== 1'b1) begin
      errors++; $display("FAIL signed_operands_stable: opA=%h opB=%h want ffffff9c/7", div_opA, div_opB); end
    checks++; if (resp_valid !== 4'b0100 || resp_id !== 2'd2 || resp_res !== 32'hFFFF_FFF2) begin
      errors++; $display("FAIL signed_resp: valid=%b id=%0d res=%h want 0100/2/fffffff2", resp_valid, resp_id, resp_res); end
  endtask

  task automatic test_zero();
    int n;
    @(posedge clk); #1;
    set_req(1, 32'd0, 32'd0);
    @(negedge clk);
    checks++; if (req_ready !== 4'b0010) begin
      errors++; $display("FAIL zero_ready: ready=%b want 0010", req_ready); end
    @(posedge clk); #1;
    req_valid = '0;
    n = 0;
    while (resp_valid == '0 && n < 100) begin @(negedge clk); n++; end
    checks++; if (resp_valid !== 4'b0010 || resp_id !== 2'd1 || resp_res !== 32'd1) begin
      errors++; $display("FAIL zero_resp: valid=%b id=%0d res=%0d want 0010/1/1 (waited %0d)", resp_valid, resp_id, resp_res, n); end
  endtask

  task automatic test_timeout();
    int n, guard;
    div_stuck = 1'b1;
    @(posedge clk); #1;
    set_req(3, 32'd9, 32'd3);
    @(negedge clk);
    checks++; if (req_ready !== 4'b1000) begin
      errors++; $display("FAIL timeout_ready: ready=%b want 1000", req_ready); end
    @(posedge clk); #1;
    req_valid = '0;
    n = 0; guard = 0;
    @(negedge clk);
    while (resp_valid == '0 && guard < 400) begin
      if (div_en) n++;
      @(negedge clk); guard++;
    end
    checks++; if (n != TO_CYCLES) begin
      errors++; $display("FAIL timeout_cycles: armed %0d cycles want %0d", n, TO_CYCLES); end
    checks++; if (resp_valid !== 4'b1000 || resp_id !== 2'd3 || resp_res !== 32'd0 || timeout_err !== 1'b1) begin
      errors++; $display("FAIL timeout_resp: valid=%b id=%0d res=%0d terr=%b want 1000/3/0/1",
                         resp_valid, resp_id, resp_res, timeout_err); end
    div_stuck = 1'b0;
    @(posedge clk); #1;
    set_req(0, 32'd81, 32'd9);
    @(negedge clk);
    @(posedge clk); #1;
    req_valid = '0;
    n = 0;
    while (resp_valid == '0 && n < 100) begin @(negedge clk); n++; end
    checks++; if (resp_valid !== 4'b0001 || resp_res !== 32'd9 || timeout_err !== 1'b1) begin
      errors++; $display("FAIL timeout_sticky: valid=%b res=%0d terr=%b want 0001/9/1", resp_valid, resp_res, timeout_err); end
  endtask

  task automatic test_reset_mid_run();
    int n;
    @(posedge clk); #1;
    set_req(1, 32'd1000, 32'd10);
    @(negedge clk);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (4) @(negedge clk);
    checks++; if (div_en !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL midrun_pre: en=%b busy=%b want 1/1", div_en, busy); end
    nrst = 1'b0;
    #1;
    checks++; if (div_en !== 1'b0 || busy !== 1'b0 || timeout_err !== 1'b0 || resp_valid !== 4'b0000) begin
      errors++; $display("FAIL midrun_reset_ctl: en=%b busy=%b terr=%b valid=%b want 0/0/0/0000",
                         div_en, busy, timeout_err, resp_valid); end
    checks++; if (resp_res !== 32'd0 || resp_id !== 2'd0 || div_opA !== 32'd0 || div_opB !== 32'd0) begin
      errors++; $display("FAIL midrun_reset_regs: res=%h id=%0d opA=%h opB=%h want 0", resp_res, resp_id, div_opA, div_opB); end
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk); #1;
    set_req(0, 32'd60, 32'hFFFF_FFFC);
    set_req(2, 32'd7, 32'd7);
    @(negedge clk);
    checks++; if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL midrun_ptr: ready=%b want 0001", req_ready); end
    @(posedge clk); #1;
    req_valid = '0;
    n = 0;
    while (resp_valid == '0 && n < 100) begin @(negedge clk); n++; end
    checks++; if (resp_valid !== 4'b0001 || resp_id !== 2'd0 || resp_res !== 32'hFFFF_FFF1) begin
      errors++; $display("FAIL midrun_after: valid=%b id=%0d res=%h want 0001/0/fffffff1", resp_valid, resp_id, resp_res); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_signed();
    test_zero();
    test_timeout();
    test_reset_mid_run();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
